// File: rtl/alu_pkg.sv
// Shared types for the ALU execution controller: ALU function codes,
// the captured flag layout and the controller state encoding.
package alu_pkg;

    // Register index width (8 architectural registers).
    localparam int IDX_W = 3;

    // ALU function codes; 3'b011 is deliberately absent and treated as illegal.
    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_ADD = 3'b010,
        OP_XOR = 3'b100,
        OP_NOR = 3'b101,
        OP_SUB = 3'b110,
        OP_SLT = 3'b111
    } alu_op_t;

    // Flag vector as presented on resp_flags: {N,V,C,Z}.
    typedef struct packed {
        logic n;
        logic v;
        logic c;
        logic z;
    } alu_flags_t;

    // Controller states: one command in flight at a time.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_t;

    // True when the function code names a real ALU operation.
    function automatic logic op_legal(input logic [2:0] f);
        case (f)
            OP_AND, OP_OR, OP_ADD, OP_XOR,
            OP_NOR, OP_SUB, OP_SLT:        op_legal = 1'b1;
            default:                       op_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// Register file: NREGS x WIDTH, two asynchronous read ports, one
// synchronous write port. Register 0 is hardwired to zero.
module alu_regfile
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NREGS = 8,
    parameter int IW    = IDX_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IW-1:0]    ra_addr_i,
    output logic [WIDTH-1:0] ra_data_o,
    input  logic [IW-1:0]    rb_addr_i,
    output logic [WIDTH-1:0] rb_data_o,
    input  logic             we_i,
    input  logic [IW-1:0]    wa_i,
    input  logic [WIDTH-1:0] wd_i
);

    logic [WIDTH-1:0] regs_q [NREGS];

    // Clear everything on reset; otherwise write, ignoring register 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (wa_i != '0)) begin
            regs_q[wa_i] <= wd_i;
        end
    end

    // Reads are combinational; register 0 always reads as zero.
    assign ra_data_o = (ra_addr_i == '0) ? '0 : regs_q[ra_addr_i];
    assign rb_data_o = (rb_addr_i == '0) ? '0 : regs_q[rb_addr_i];

endmodule

// File: rtl/alu_exec_ctrl.sv
// ALU execution controller: accepts one register-to-register command,
// drives an external combinational ALU for one cycle, writes the result
// back and presents it on a valid/ready response channel.
module alu_exec_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NREGS = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_f,
    input  logic [IDX_W-1:0] cmd_rd,
    input  logic [IDX_W-1:0] cmd_rs,
    input  logic [IDX_W-1:0] cmd_rt,
    input  logic             cmd_imm_en,
    input  logic [WIDTH-1:0] cmd_imm,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_f,
    input  logic [WIDTH-1:0] alu_y,
    input  logic             alu_zero,
    input  logic             alu_carry,
    input  logic             alu_overflow,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_y,
    output logic [3:0]       resp_flags,
    output logic             resp_err
);

    state_t           state_q, state_d;
    logic [2:0]       f_q;
    logic [IDX_W-1:0] rd_q, rs_q, rt_q;
    logic             imm_en_q;
    logic [WIDTH-1:0] imm_q;
    logic [WIDTH-1:0] y_q;
    alu_flags_t       flags_q;
    logic             err_q;

    logic [WIDTH-1:0] rs_data, rt_data;
    logic             legal;
    logic             accept;
    logic             wr_en;

    assign legal = op_legal(f_q);

    // Operands are read from the register file before the EXEC-edge write,
    // so rd == rs/rt sees the old value.
    alu_regfile #(
        .WIDTH (WIDTH),
        .NREGS (NREGS),
        .IW    (IDX_W)
    ) u_regfile (
        .clk       (clk),
        .reset     (reset),
        .ra_addr_i (rs_q),
        .ra_data_o (rs_data),
        .rb_addr_i (rt_q),
        .rb_data_o (rt_data),
        .we_i      (wr_en),
        .wa_i      (rd_q),
        .wd_i      (alu_y)
    );

    // Next-state, handshake and ALU drive; everything defaults to idle/zero.
    always_comb begin
        state_d    = state_q;
        cmd_ready  = 1'b0;
        resp_valid = 1'b0;
        accept     = 1'b0;
        wr_en      = 1'b0;
        alu_a      = '0;
        alu_b      = '0;
        alu_f      = '0;
        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    accept  = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                alu_a   = rs_data;
                alu_b   = imm_en_q ? imm_q : rt_data;
                alu_f   = f_q;
                wr_en   = legal;
                state_d = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, command capture on accept and result capture at the end of EXEC.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            f_q      <= '0;
            rd_q     <= '0;
            rs_q     <= '0;
            rt_q     <= '0;
            imm_en_q <= 1'b0;
            imm_q    <= '0;
            y_q      <= '0;
            flags_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                f_q      <= cmd_f;
                rd_q     <= cmd_rd;
                rs_q     <= cmd_rs;
                rt_q     <= cmd_rt;
                imm_en_q <= cmd_imm_en;
                imm_q    <= cmd_imm;
            end
            if (state_q == EXEC) begin
                if (legal) begin
                    y_q     <= alu_y;
                    flags_q <= '{n: alu_y[WIDTH-1], v: alu_overflow,
                                 c: alu_carry,      z: alu_zero};
                    err_q   <= 1'b0;
                end else begin
                    y_q     <= '0;
                    flags_q <= '0;
                    err_q   <= 1'b1;
                end
            end
        end
    end

    assign resp_y     = y_q;
    assign resp_flags = flags_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Testbench for alu_exec_ctrl with a behavioural 16-bit ALU attached and a
// scoreboard of expected responses built from a shadow register file.
module tb_alu_exec_ctrl;

    logic        clk;
    logic        reset;
    logic        cmd_valid, cmd_ready;
    logic [2:0]  cmd_f, cmd_rd, cmd_rs, cmd_rt;
    logic        cmd_imm_en;
    logic [15:0] cmd_imm;
    logic [15:0] alu_a, alu_b, alu_y;
    logic [2:0]  alu_f;
    logic        alu_zero, alu_carry, alu_overflow;
    logic        resp_valid, resp_ready;
    logic [15:0] resp_y;
    logic [3:0]  resp_flags;
    logic        resp_err;

    typedef struct packed {
        logic [15:0] y;
        logic [3:0]  fl;
        logic        err;
    } resp_t;

    int          n_checks = 0;
    int          n_pass   = 0;
    resp_t       sb_q[$];
    logic [15:0] rf_m [8];

    alu_exec_ctrl #(.WIDTH(16), .NREGS(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_f        (cmd_f),
        .cmd_rd       (cmd_rd),
        .cmd_rs       (cmd_rs),
        .cmd_rt       (cmd_rt),
        .cmd_imm_en   (cmd_imm_en),
        .cmd_imm      (cmd_imm),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_f        (alu_f),
        .alu_y        (alu_y),
        .alu_zero     (alu_zero),
        .alu_carry    (alu_carry),
        .alu_overflow (alu_overflow),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_y       (resp_y),
        .resp_flags   (resp_flags),
        .resp_err     (resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU: returns {carry, overflow, y}. SUB carry is the carry out
    // of a + ~b + 1. Illegal code returns junk so masking is observable.
    function automatic logic [17:0] alu_ref(input logic [15:0] a, input logic [15:0] b,
                                            input logic [2:0] f);
        logic [16:0] s;
        logic [15:0] y;
        logic        c, v;
        c = 1'b0; v = 1'b0; y = '0; s = '0;
        case (f)
            3'b000: y = a & b;
            3'b001: y = a | b;
            3'b010: begin
                s = {1'b0, a} + {1'b0, b};
                y = s[15:0]; c = s[16];
                v = (a[15] == b[15]) && (y[15] != a[15]);
            end
            3'b100: y = a ^ b;
            3'b101: y = ~(a | b);
            3'b110: begin
                s = {1'b0, a} + {1'b0, ~b} + 17'd1;
                y = s[15:0]; c = s[16];
                v = (a[15] != b[15]) && (y[15] != a[15]);
            end
            3'b111: y = ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
            default: begin y = 16'hDEAD; c = 1'b1; v = 1'b1; end
        endcase
        return {c, v, y};
    endfunction

    // External combinational ALU connected to the controller.
    logic [17:0] alu_r;
    always_comb alu_r = alu_ref(alu_a, alu_b, alu_f);
    assign alu_y        = alu_r[15:0];
    assign alu_overflow = alu_r[16];
    assign alu_carry    = alu_r[17];
    assign alu_zero     = (alu_r[15:0] == 16'd0);

    // Expected response from the shadow register file.
    function automatic resp_t expect_op(input logic [2:0] f, input logic [2:0] rs,
                                        input logic [2:0] rt, input logic ie,
                                        input logic [15:0] imm);
        logic [15:0] a, b;
        logic [17:0] r;
        resp_t       e;
        a = rf_m[rs];
        b = ie ? imm : rf_m[rt];
        if (f == 3'b011) begin
            e = '{y: 16'd0, fl: 4'd0, err: 1'b1};
        end else begin
            r = alu_ref(a, b, f);
            e = '{y: r[15:0], fl: {r[15], r[16], r[17], (r[15:0] == 16'd0)}, err: 1'b0};
        end
        return e;
    endfunction

    task automatic sb_push(input logic [2:0] f, input logic [2:0] rd, input logic [2:0] rs,
                           input logic [2:0] rt, input logic ie, input logic [15:0] imm);
        resp_t e;
        e = expect_op(f, rs, rt, ie, imm);
        sb_q.push_back(e);
        if (f != 3'b011 && rd != 3'd0) rf_m[rd] = e.y;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 8; i++) rf_m[i] = 16'd0;
        sb_q.delete();
    endtask

    // Drive one command, wait for its response and accept it.
    task automatic exec_cmd(input logic [2:0] f, input logic [2:0] rd, input logic [2:0] rs,
                            input logic [2:0] rt, input logic ie, input logic [15:0] imm,
                            output resp_t obs, output int lat,
                            output logic [34:0] ex_alu, output logic [34:0] rsp_alu);
        int w;
        w = 0;
        while (!cmd_ready && w < 20) begin @(posedge clk); #1; w++; end
        if (!cmd_ready) begin
            n_checks++;
            $display("FAIL cmd_ready_timeout: cmd_ready=%b required 1", cmd_ready);
        end
        cmd_f = f; cmd_rd = rd; cmd_rs = rs; cmd_rt = rt; cmd_imm_en = ie; cmd_imm = imm;
        cmd_valid = 1'b1;
        sb_push(f, rd, rs, rt, ie, imm);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        ex_alu = {alu_a, alu_b, alu_f};
        lat = 1;
        while (!resp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        if (!resp_valid) begin
            n_checks++;
            $display("FAIL resp_timeout: resp_valid=%b required 1", resp_valid);
        end
        obs     = '{y: resp_y, fl: resp_flags, err: resp_err};
        rsp_alu = {alu_a, alu_b, alu_f};
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    task automatic read_reg(input logic [2:0] idx, output logic [15:0] v);
        resp_t       obs, e;
        int          lat;
        logic [34:0] ea, ra;
        exec_cmd(3'b001, 3'd0, idx, 3'd0, 1'b1, 16'd0, obs, lat, ea, ra);
        e = sb_q.pop_front();
        v = obs.y;
    endtask

    task automatic test_reset();
        reset = 1'b1; cmd_valid = 1'b1; resp_ready = 1'b1;
        cmd_f = 3'b010; cmd_rd = 3'd1; cmd_rs = 3'd0; cmd_rt = 3'd0;
        cmd_imm_en = 1'b1; cmd_imm = 16'h1234;
        repeat (3) @(posedge clk);
        #1;
        cmd_valid = 1'b0; resp_ready = 1'b0;
        n_checks++;
        if ({cmd_ready, resp_valid, resp_err} !== 3'b100)
            $display("FAIL reset_ctrl: {rdy,vld,err}=%b required 100", {cmd_ready, resp_valid, resp_err});
        else n_pass++;
        n_checks++;
        if ({alu_a, alu_b, alu_f} !== 35'd0)
            $display("FAIL reset_alu: a=%h b=%h f=%b required 0", alu_a, alu_b, alu_f);
        else n_pass++;
        n_checks++;
        if ({resp_y, resp_flags} !== 20'd0)
            $display("FAIL reset_resp: y=%h flags=%b required 0", resp_y, resp_flags);
        else n_pass++;
        reset = 1'b0;
        clear_model();
    endtask

    task automatic test_add_overflow();
        resp_t       obs, e;
        int          lat;
        logic [34:0] ea, ra;
        logic [15:0] v;
        exec_cmd(3'b010, 3'd1, 3'd0, 3'd0, 1'b1, 16'h7FFF, obs, lat, ea, ra);
        e = sb_q.pop_front();
        n_checks++;
        if (obs !== e) $display("FAIL add1: got %h required %h", obs, e); else n_pass++;
        exec_cmd(3'b010, 3'd2, 3'd1, 3'd0, 1'b1, 16'h0001, obs, lat, ea, ra);
        e = sb_q.pop_front();
        n_checks++;
        if (obs !== e) $display("FAIL add2: got %h required %h", obs, e); else n_pass++;
        n_checks++;
        if (obs !== {16'h8000, 4'b1100, 1'b0})
            $display("FAIL add2_const: y=%h fl=%b err=%b required 8000 1100 0", obs.y, obs.fl, obs.err);
        else n_pass++;
        n_checks++;
        if (ea !== {16'h7FFF, 16'h0001, 3'b010})
            $display("FAIL add2_alu_drive: got %h required %h", ea, {16'h7FFF, 16'h0001, 3'b010});
        else n_pass++;
        n_checks++;
        if (ra !== 35'd0) $display("FAIL alu_idle_in_resp: got %h required 0", ra); else n_pass++;
        read_reg(3'd2, v);
        n_checks++;
        if (v !== 16'h8000) $display("FAIL r2_value: got %h required 8000", v); else n_pass++;
    endtask

    task automatic test_sub_latency();
        resp_t       obs, e;
        int          lat;
        logic [34:0] ea, ra;
        exec_cmd(3'b110, 3'd3, 3'd1, 3'd1, 1'b0, 16'hFFFF, obs, lat, ea, ra);
        e = sb_q.pop_front();
        n_checks++;
        if (obs !== e) $display("FAIL sub: got %h required %h", obs, e); else n_pass++;
        n_checks++;
        if ({obs.y, obs.fl[3], obs.fl[2], obs.fl[0]} !== {16'h0000, 1'b0, 1'b0, 1'b1})
            $display("FAIL sub_const: y=%h fl=%b required y=0 N=0 V=0 Z=1", obs.y, obs.fl);
        else n_pass++;
        n_checks++;
        if (lat !== 2) $display("FAIL latency: got %0d required 2", lat); else n_pass++;
    endtask

    task automatic test_illegal();
        resp_t       obs, e;
        int          lat;
        logic [34:0] ea, ra;
        logic [15:0] v;
        exec_cmd(3'b011, 3'd1, 3'd1, 3'd0, 1'b1, 16'h0005, obs, lat, ea, ra);
        e = sb_q.pop_front();
        n_checks++;
        if (obs !== e) $display("FAIL illegal: got %h required %h", obs, e); else n_pass++;
        n_checks++;
        if (obs !== {16'h0000, 4'b0000, 1'b1})
            $display("FAIL illegal_const: y=%h fl=%b err=%b required 0 0000 1", obs.y, obs.fl, obs.err);
        else n_pass++;
        read_reg(3'd1, v);
        n_checks++;
        if (v !== 16'h7FFF) $display("FAIL r1_after_illegal: got %h required 7fff", v); else n_pass++;
        exec_cmd(3'b010, 3'd0, 3'd1, 3'd0, 1'b1, 16'h0001, obs, lat, ea, ra);
        e = sb_q.pop_front();
        n_checks++;
        if (obs !== e) $display("FAIL add_rd0: got %h required %h", obs, e); else n_pass++;
        read_reg(3'd0, v);
        n_checks++;
        if (v !== 16'h0000) $display("FAIL r0_zero: got %h required 0", v); else n_pass++;
    endtask

    task automatic test_backpressure();
        resp_t       e;
        logic [20:0] held;
        logic [15:0] v;
        cmd_f = 3'b100; cmd_rd = 3'd6; cmd_rs = 3'd1; cmd_rt = 3'd0;
        cmd_imm_en = 1'b1; cmd_imm = 16'h00FF; cmd_valid = 1'b1;
        sb_push(3'b100, 3'd6, 3'd1, 3'd0, 1'b1, 16'h00FF);
        @(posedge clk); #1;
        // a second command stays offered; it must not be taken
        cmd_f = 3'b010; cmd_rd = 3'd7; cmd_rs = 3'd1; cmd_imm = 16'h1234;
        @(posedge clk); #1;
        held = {resp_y, resp_flags, resp_err};
        e = sb_q.pop_front();
        n_checks++;
        if (held !== e) $display("FAIL bp_resp: got %h required %h", held, e); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if ({resp_valid, cmd_ready, resp_y, resp_flags, resp_err} !== {1'b1, 1'b0, held})
                $display("FAIL bp_hold%0d: vld=%b rdy=%b out=%h required 1 0 %h",
                         i, resp_valid, cmd_ready, {resp_y, resp_flags, resp_err}, held);
            else n_pass++;
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0; resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        n_checks++;
        if ({cmd_ready, resp_valid} !== 2'b10)
            $display("FAIL bp_release: rdy=%b vld=%b required 1 0", cmd_ready, resp_valid);
        else n_pass++;
        read_reg(3'd7, v);
        n_checks++;
        if (v !== rf_m[7]) $display("FAIL bp_no_second: r7=%h required %h", v, rf_m[7]); else n_pass++;
    endtask

    task automatic test_reset_exec();
        int          seen;
        logic [15:0] v;
        cmd_f = 3'b010; cmd_rd = 3'd4; cmd_rs = 3'd1; cmd_rt = 3'd0;
        cmd_imm_en = 1'b1; cmd_imm = 16'h0001; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0; reset = 1'b1; resp_ready = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        clear_model();
        n_checks++;
        if ({cmd_ready, resp_valid} !== 2'b10)
            $display("FAIL rst_exec_ctrl: rdy=%b vld=%b required 1 0", cmd_ready, resp_valid);
        else n_pass++;
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (resp_valid !== 1'b0) seen++;
        end
        resp_ready = 1'b0;
        n_checks++;
        if (seen !== 0) $display("FAIL rst_exec_noresp: resp_valid seen %0d required 0", seen); else n_pass++;
        read_reg(3'd4, v);
        n_checks++;
        if (v !== 16'h0000) $display("FAIL rst_exec_r4: got %h required 0", v); else n_pass++;
    endtask

    task automatic test_slt_logic();
        resp_t       obs, e;
        int          lat;
        logic [34:0] ea, ra;
        logic [2:0]  ops [4];
        ops[0] = 3'b000; ops[1] = 3'b001; ops[2] = 3'b100; ops[3] = 3'b101;
        exec_cmd(3'b010, 3'd1, 3'd0, 3'd0, 1'b1, 16'h8000, obs, lat, ea, ra);
        e = sb_q.pop_front();
        n_checks++;
        if (obs !== e) $display("FAIL slt_setup: got %h required %h", obs, e); else n_pass++;
        exec_cmd(3'b111, 3'd5, 3'd1, 3'd0, 1'b1, 16'h0001, obs, lat, ea, ra);
        e = sb_q.pop_front();
        n_checks++;
        if (obs.y !== 16'h0001 || obs !== e)
            $display("FAIL slt: got %h required y=0001 (%h)", obs, e);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            exec_cmd(ops[i], 3'd6, 3'd1, 3'd0, 1'b1, 16'h0F0F, obs, lat, ea, ra);
            e = sb_q.pop_front();
            n_checks++;
            if (obs !== e || obs.fl[2:1] !== 2'b00)
                $display("FAIL logic_op%0d: got %h required %h with C=V=0", i, obs, e);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        resp_t e;
        int    accepts, resps;
        accepts = 0; resps = 0;
        cmd_f = 3'b010; cmd_rd = 3'd1; cmd_rs = 3'd1; cmd_rt = 3'd0;
        cmd_imm_en = 1'b1; cmd_imm = 16'h0001;
        cmd_valid = 1'b1; resp_ready = 1'b1;
        for (int c = 0; c < 9; c++) begin
            if (cmd_ready) begin
                accepts++;
                sb_push(3'b010, 3'd1, 3'd1, 3'd0, 1'b1, 16'h0001);
            end
            if (resp_valid) begin
                resps++;
                n_checks++;
                if (sb_q.size() == 0) begin
                    $display("FAIL b2b_spurious: resp_valid=1 required no response");
                end else begin
                    e = sb_q.pop_front();
                    if ({resp_y, resp_flags, resp_err} !== e)
                        $display("FAIL b2b_resp%0d: got %h required %h", c, {resp_y, resp_flags, resp_err}, e);
                    else n_pass++;
                end
            end
            if (c == 8) cmd_valid = 1'b0;
            @(posedge clk); #1;
        end
        resp_ready = 1'b0;
        n_checks++;
        if (accepts !== 3 || resps !== 3)
            $display("FAIL b2b_rate: accepts=%0d resps=%0d required 3 3", accepts, resps);
        else n_pass++;
        sb_q.delete();
    endtask

    task automatic test_random();
        resp_t       obs, e;
        int          lat;
        logic [34:0] ea, ra;
        logic [2:0]  f, rd, rs, rt;
        logic        ie;
        logic [15:0] imm;
        for (int i = 0; i < 16; i++) begin
            f   = 3'($urandom_range(0, 7));
            rd  = 3'($urandom_range(0, 7));
            rs  = 3'($urandom_range(0, 7));
            rt  = (i % 3 == 0) ? rd : 3'($urandom_range(0, 7));
            ie  = 1'($urandom_range(0, 1));
            imm = 16'($urandom);
            exec_cmd(f, rd, rs, rt, ie, imm, obs, lat, ea, ra);
            e = sb_q.pop_front();
            n_checks++;
            if (obs !== e) $display("FAIL rand%0d f=%b: got %h required %h", i, f, obs, e); else n_pass++;
        end
    endtask

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; resp_ready = 1'b0;
        cmd_f = '0; cmd_rd = '0; cmd_rs = '0; cmd_rt = '0; cmd_imm_en = 1'b0; cmd_imm = '0;
        clear_model();
        test_reset();
        test_add_overflow();
        test_sub_latency();
        test_illegal();
        test_backpressure();
        test_reset_exec();
        test_slt_logic();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
